// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: R-format function codes,
// FSM state encoding and the sign/correction record carried into FIX.
package muldiv_unit_pkg;

    localparam logic [5:0] OP_R_FORM = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Everything FIX needs to turn the unsigned iteration result into HI/LO.
    typedef struct packed {
        logic is_div;
        logic neg_res;   // negate product / quotient
        logic neg_rem;   // negate remainder
        logic div_zero;  // divisor was zero
    } fix_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Decode-to-muldiv handshake: operation request, operands, status and HI/LO.
interface muldiv_unit_if #(parameter int XLEN = 32);

    logic            Start;
    logic [5:0]      Func;
    logic [XLEN-1:0] Rs;
    logic [XLEN-1:0] Rt;
    logic            Busy;
    logic            Stall;
    logic            Done;
    logic [XLEN-1:0] Rdata;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output Start, Func, Rs, Rt,
        input  Busy, Stall, Done, Rdata, HI, LO
    );

    modport slave (
        input  Start, Func, Rs, Rt,
        output Busy, Stall, Done, Rdata, HI, LO
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative datapath: one shift-add multiply step or one restoring divide step
// per enabled cycle. acc holds {partial product, multiplier} or {remainder, quotient}.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   load_lo_i,
    input  logic [XLEN-1:0]   load_opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (latch).
        acc_d  = acc_q;
        opnd_d = opnd_q;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};

        if (load_i) begin
            acc_d  = {{XLEN{1'b0}}, load_lo_i};
            opnd_d = load_opnd_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Borrow out means the divisor did not fit: restore and shift in 0.
                acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    // NOTE: the datapath is reset too, so a fresh operation never depends on stale X state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO; stalls decode while an iteration runs.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic           CLK,
    input  logic           RST,
    muldiv_unit_if.slave   bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    fix_t              fix_q, fix_d;

    logic              load;
    logic              signed_op;
    logic              rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_mag, rt_mag;
    logic [XLEN-1:0]   load_lo, load_opnd;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quo, rem;

    // Magnitudes feed the unsigned datapath; signs are replayed in FIX.
    assign signed_op = (bus.Func == FN_MULT) || (bus.Func == FN_DIV);
    assign rs_neg    = signed_op & bus.Rs[XLEN-1];
    assign rt_neg    = signed_op & bus.Rt[XLEN-1];
    assign rs_mag    = rs_neg ? -bus.Rs : bus.Rs;
    assign rt_mag    = rt_neg ? -bus.Rt : bus.Rt;
    assign rem       = acc[2*XLEN-1:XLEN];
    assign quo       = acc[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        fix_d     = fix_q;
        load      = 1'b0;
        load_lo   = rt_mag;
        load_opnd = rs_mag;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (bus.Func)
                        FN_MTHI: hi_d = bus.Rs;
                        FN_MTLO: lo_d = bus.Rs;
                        FN_MULT, FN_MULTU: begin
                            load    = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_MUL;
                            fix_d   = '{is_div: 1'b0, neg_res: rs_neg ^ rt_neg,
                                        neg_rem: 1'b0, div_zero: 1'b0};
                        end
                        FN_DIV, FN_DIVU: begin
                            load      = 1'b1;
                            load_lo   = rs_mag;
                            load_opnd = rt_mag;
                            cnt_d     = '0;
                            state_d   = ST_DIV;
                            fix_d     = '{is_div: 1'b1, neg_res: rs_neg ^ rt_neg,
                                          neg_rem: rs_neg, div_zero: (bus.Rt == '0)};
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (fix_q.is_div) begin
                    // Divide-by-zero leaves the dividend in the remainder naturally.
                    lo_d = fix_q.div_zero ? {XLEN{1'b1}} : (fix_q.neg_res ? -quo : quo);
                    hi_d = fix_q.neg_rem ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = fix_q.neg_res ? -acc : acc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            fix_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            fix_q   <= fix_d;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .load_i      (load),
        .step_i      ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .is_div_i    (state_q == ST_DIV),
        .load_lo_i   (load_lo),
        .load_opnd_i (load_opnd),
        .acc_o       (acc)
    );

    always_comb begin
        bus.Rdata = '0;
        if (bus.Func == FN_MFHI)      bus.Rdata = hi_q;
        else if (bus.Func == FN_MFLO) bus.Rdata = lo_q;
    end

    assign bus.Busy  = (state_q != ST_IDLE);
    assign bus.Stall = bus.Busy & bus.Start;
    assign bus.Done  = (state_q == ST_FIX);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage, directly downstream of instruction decode. It consumes the R-format MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations and the two register read operands produced by decode. It owns the architectural HI/LO registers and tells decode to stall when an MFHI/MFLO arrives while a multiply or divide is still in flight.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-low reset.
Start  in  1  operation valid this cycle; asserted by decode when op is R_FORM and Func is one of the eight HI/LO functions.
Func  in  6  R-format function field; uses the MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU codes.
Rs  in  XLEN  first register read operand; dividend or multiplicand; source for MTHI/MTLO.
Rt  in  XLEN  second register read operand; divisor or multiplier.
Busy  out  1  high while an iterative operation is in progress.
Stall  out  1  request for decode to hold the current instruction.
Done  out  1  one-cycle pulse on the cycle HI/LO take an iterative result.
Rdata  out  XLEN  result of MFHI (HI) or MFLO (LO); combinational from Func.
HI  out  XLEN  HI register.
LO  out  XLEN  LO register.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - HI, LO and the counter go to 0.
  - Busy, Stall and Done go to 0.
  - Reset during MUL/DIV/FIX aborts the operation; no Done is issued.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE with Start=1:
  - MTHI: HI <= Rs at the next edge; LO unchanged; single cycle; no Done.
  - MTLO: LO <= Rs at the next edge; HI unchanged; single cycle; no Done.
  - MFHI/MFLO: Rdata is valid in the same cycle; no state change.
  - MULT/MULTU: latch operands, counter <= 0, go to MUL.
  - DIV/DIVU: latch operands, counter <= 0, go to DIV.
  - Signed variants latch operand magnitudes and record the result signs.
- MUL:
  - One shift-add step per cycle on a 2*XLEN accumulator.
  - After XLEN steps, go to FIX.
- DIV:
  - One restoring step per cycle: shift the remainder and compare against the divisor.
  - After XLEN steps, go to FIX.
- FIX (1 cycle):
  - Apply signed corrections, write HI/LO, pulse Done, return to IDLE.
  - Multiply: {HI,LO} = 64-bit product; negated when exactly one operand is negative (signed MULT only).
  - Divide: LO = quotient, HI = remainder.
  - Signed quotient is negative when operand signs differ; signed remainder takes the dividend's sign.
- Latency: MULT/MULTU/DIV/DIVU issued at edge N are in HI/LO after edge N+XLEN+1 (33 cycles at XLEN=32). Done is high in the cycle before that edge.
- Busy = 1 in MUL, DIV and FIX.
- Stall = Busy & Start:
  - Any HI/LO operation presented while Busy is held and has no effect.
  - Decode re-presents it; it is accepted in the first cycle that Busy=0.
- Division by zero: LO = all ones, HI = dividend (Rs) unchanged, for both DIV and DIVU. Normal latency; no exception.
- Overflow case, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Start=0: no state change.
- Func not among the eight HI/LO codes: ignored, no state change.

Decomposition:
- Func codes (MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU) and the R_FORM opcode live in the shared common_param.vh.
- FSM state encodings are added to common_param.vh as well.
- One sub-module, muldiv_iter: holds the accumulator, remainder and quotient shift registers and performs one multiply or divide step per enabled cycle.
- The top level keeps the FSM, counter, sign handling, HI/LO and Stall.

Test Plan:
- MULT Rs=0xFFFFFFFE, Rt=3 -> Busy for 33 cycles, Done pulses once; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU Rs=0xFFFFFFFF, Rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV Rs=0xFFFFFFF9 (-7), Rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU Rs=100, Rt=0 -> LO=0xFFFFFFFF, HI=0x00000064 after 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO presented 5 cycles after MULT 6*7 -> Stall=1 until Busy drops; MFLO then returns Rdata=42 with Stall=0.
- MTHI Rs=0x12345678 while idle -> HI=0x12345678 next cycle, LO unchanged.
- RST low at cycle 10 of a DIV -> HI=LO=0, Busy=0 immediately.
- After RST returns high -> a new DIVU 9/4 gives LO=2, HI=1.
